// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
//   Shared definitions for the bit-serial adder/subtractor.
//   OP_ADD / OP_SUB : values of the op select input.
//   state_t         : FSM state encoding (IDLE, RUN, DONE).
package serial_addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : serial_addsub_pkg

// File: rtl/serial_addsub_full_adder.sv
// serial_addsub_full_adder
//   Single-bit full adder cell used as the bit-serial ALU slice.
//   Ports:
//     sum  - a ^ b ^ cin
//     cout - majority(a, b, cin)
//     a, b - operand bits
//     cin  - carry in
module serial_addsub_full_adder (
   output logic sum,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic cin
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : serial_addsub_full_adder

// File: rtl/serial_addsub.sv
// serial_addsub
//   Bit-serial two's-complement adder/subtractor. Operands are captured on a
//   start pulse and processed LSB first, one bit per clock, through a single
//   full-adder slice with a registered carry. Latency is WIDTH cycles from the
//   start edge; done pulses for one cycle when result and flags are valid.
//
//   Optional build macro SERIAL_ADDSUB_SAT_EN: when defined, an overflowing
//   result is clamped to max positive / min negative. ovf and cout still
//   report the raw condition.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start
//   RUN   | processing one bit per clock, WIDTH clocks
//   DONE  | one cycle, done=1; a start here is accepted as in IDLE
//
//   Ports:
//     clk    - rising-edge clock
//     rst    - synchronous active-high reset
//     start  - request, sampled only when busy=0
//     op     - 0 = a+b, 1 = a-b
//     a, b   - WIDTH-bit two's-complement operands
//     busy   - high while bits are being processed
//     done   - one-cycle pulse, result and flags valid
//     result - sum / difference (held until next completion or rst)
//     cout   - final carry; on subtract 1 = no borrow
//     ovf    - signed overflow
//     zero   - result == 0
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   // Partial sum: holds the WIDTH-1 bits already produced; the bit computed
   // on the current clock completes the word.
   logic [WIDTH-2:0]   r_sum;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;

   logic [WIDTH-1:0]   r_result;
   logic               r_cout;
   logic               r_ovf;
   logic               r_zero;

   logic               w_load;
   logic               w_step;
   logic               w_last;
   logic               w_sum;
   logic               w_cout;
   logic               w_ovf;
   logic [WIDTH-1:0]   w_res_raw;
   logic [WIDTH-1:0]   w_res_final;

   serial_addsub_full_adder u_fa (
      .sum  (w_sum),
      .cout (w_cout),
      .a    (r_a[0]),
      .b    (r_b[0]),
      .cin  (r_carry)
   );

   assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_res_raw = {w_sum, r_sum};
   // On the last bit r_carry is the carry into the MSB.
   assign w_ovf     = r_carry ^ w_cout;

`ifdef SERIAL_ADDSUB_SAT_EN
   always_comb begin
      w_res_final = w_res_raw;
      if (w_ovf) begin
         if (r_carry) begin
            w_res_final = {1'b0, {(WIDTH-1){1'b1}}};
         end else begin
            w_res_final = {1'b1, {(WIDTH-1){1'b0}}};
         end
      end
   end
`else
   assign w_res_final = w_res_raw;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            busy   = 1'b1;
            w_step = 1'b1;
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_sum    <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
      end else if (w_load) begin
         r_a     <= a;
         // Subtraction is a + ~b + 1: invert b and seed the carry with op.
         r_b     <= (op == OP_SUB) ? ~b : b;
         r_carry <= op;
         r_cnt   <= '0;
      end else if (w_step) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_sum   <= w_res_raw[WIDTH-1:1];
         r_carry <= w_cout;
         r_cnt   <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_result <= w_res_final;
            r_cout   <= w_cout;
            r_ovf    <= w_ovf;
            r_zero   <= (w_res_final == '0);
         end
      end
   end

   assign result = r_result;
   assign cout   = r_cout;
   assign ovf    = r_ovf;
   assign zero   = r_zero;

endmodule : serial_addsub

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub
//   Drives a WIDTH=4 and a WIDTH=8 instance of serial_addsub. A reference
//   model computes expected outputs from plain signed/unsigned arithmetic and
//   the start/busy/done timing rules; a negedge process compares every cycle.
//   Directed cases carry hand-computed literal expectations; a random phase
//   follows. Build with +define+SERIAL_ADDSUB_SAT_EN for the clamped variant.
module tb_serial_addsub;

   logic        clk = 1'b0;
   logic [1:0]  rst_v   = 2'b11;
   logic [1:0]  start_v = 2'b00;
   logic [1:0]  op_v    = 2'b00;
   logic [31:0] av [2];
   logic [31:0] bv [2];
   logic [1:0]  busy_v, done_v, cout_v, ovf_v, zero_v;
   logic [3:0]  r4;
   logic [7:0]  r8;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .op(op_v[0]),
      .a(av[0][3:0]), .b(bv[0][3:0]),
      .busy(busy_v[0]), .done(done_v[0]), .result(r4),
      .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0])
   );

   serial_addsub #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .op(op_v[1]),
      .a(av[1][7:0]), .b(bv[1][7:0]),
      .busy(busy_v[1]), .done(done_v[1]), .result(r8),
      .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1])
   );

   function automatic int wid(input int i);
      return (i == 0) ? 4 : 8;
   endfunction

   function automatic logic [31:0] get_res(input int i);
      return (i == 0) ? {28'd0, r4} : {24'd0, r8};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference arithmetic: signed and unsigned interpretation of the operands.
   function automatic void model_op(input int w, input logic o,
                                    input logic [31:0] a_in, input logic [31:0] b_in,
                                    output logic [31:0] res, output logic co,
                                    output logic ov);
      longint m, ua, ub, sa, sb, sr;
      m  = longint'(1) << w;
      ua = longint'(a_in) & (m - 1);
      ub = longint'(b_in) & (m - 1);
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      if (o) begin
         sr = sa - sb;
         co = (ua >= ub);
      end else begin
         sr = sa + sb;
         co = ((ua + ub) >= m);
      end
      ov  = (sr > m / 2 - 1) || (sr < -(m / 2));
      res = 32'((sr + 2 * m) & (m - 1));
`ifdef SERIAL_ADDSUB_SAT_EN
      if (ov) res = (sr > 0) ? 32'(m / 2 - 1) : 32'(m / 2);
`endif
   endfunction

   // Model timing: start accepted at edge k -> busy after edges k..k+W-1,
   // outputs and done after edge k+W.
   int          n_edge = 0;
   bit          m_act [2];
   int          m_due [2];
   logic [31:0] p_res [2];
   logic        p_cout [2], p_ovf [2];
   logic [31:0] e_res [2];
   logic        e_cout [2], e_ovf [2], e_zero [2], e_busy [2], e_done [2];

   always @(posedge clk) begin
      n_edge++;
      for (int i = 0; i < 2; i++) begin
         if (rst_v[i]) begin
            m_act[i] = 1'b0;
            e_res[i] = '0; e_cout[i] = 1'b0; e_ovf[i] = 1'b0; e_zero[i] = 1'b0;
         end else begin
            if (m_act[i] && n_edge == m_due[i]) begin
               e_res[i]  = p_res[i];
               e_cout[i] = p_cout[i];
               e_ovf[i]  = p_ovf[i];
               e_zero[i] = (p_res[i] == 0);
            end
            if (start_v[i] && !(m_act[i] && n_edge <= m_due[i])) begin
               model_op(wid(i), op_v[i], av[i], bv[i], p_res[i], p_cout[i], p_ovf[i]);
               m_act[i] = 1'b1;
               m_due[i] = n_edge + wid(i);
            end
         end
         e_busy[i] = m_act[i] && (n_edge < m_due[i]);
         e_done[i] = m_act[i] && (n_edge == m_due[i]);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk((i == 0) ? "u4_cycle" : "u8_cycle",
                {27'd0, busy_v[i], done_v[i], cout_v[i], ovf_v[i], zero_v[i], get_res(i)},
                {27'd0, e_busy[i], e_done[i], e_cout[i], e_ovf[i], e_zero[i], e_res[i]});
         end
      end
   end

   // Issue one operation on instance i and wait for done. Returns at the
   // negedge of the DONE cycle. b2b=1 issues start in the current cycle.
   task automatic do_op(input int i, input logic o, input logic [31:0] a_in,
                        input logic [31:0] b_in, input int hold, input bit b2b);
      int  lat;
      bit  got;
      if (!b2b) @(negedge clk);
      op_v[i] = o; av[i] = a_in; bv[i] = b_in; start_v[i] = 1'b1;
      repeat (hold) @(negedge clk);
      start_v[i] = 1'b0;
      lat = hold - 1;
      got = 1'b0;
      for (int c = 0; c < 3 * wid(i) + 10; c++) begin
         // Inputs changing during RUN must have no effect.
         av[i] = $urandom; bv[i] = $urandom; op_v[i] = 1'($urandom);
         @(negedge clk);
         lat++;
         if (done_v[i]) begin
            got = 1'b1;
            break;
         end
      end
      chk("done_seen", 64'(got), 64'd1);
      chk("latency", 64'(lat), 64'(wid(i)));
   endtask

   initial begin
      logic [31:0] mr;
      logic        mc, mo;
      bit          saw_done;

      av[0] = '0; bv[0] = '0; av[1] = '0; bv[1] = '0;

      // Pin the model itself.
      model_op(4, 1'b1, 32'd5, 32'd3, mr, mc, mo);
      chk("model_5m3", {30'd0, mc, mo, mr}, {30'd0, 1'b1, 1'b0, 32'd2});
      model_op(8, 1'b0, 32'h7F, 32'h01, mr, mc, mo);
`ifdef SERIAL_ADDSUB_SAT_EN
      chk("model_7Fp1", {30'd0, mc, mo, mr}, {30'd0, 1'b0, 1'b1, 32'h7F});
`else
      chk("model_7Fp1", {30'd0, mc, mo, mr}, {30'd0, 1'b0, 1'b1, 32'h80});
`endif

      repeat (2) @(negedge clk);
      chk("reset_u4", {busy_v[0], done_v[0], cout_v[0], ovf_v[0], zero_v[0], r4}, 9'd0);
      chk("reset_u8", {busy_v[1], done_v[1], cout_v[1], ovf_v[1], zero_v[1], r8}, 13'd0);
      rst_v   = 2'b00;
      chk_en  = 1'b1;

      // WIDTH=4 directed cases.
      do_op(0, 1'b1, 32'd5, 32'd3, 1, 1'b0);
      chk("sub_5_3", {cout_v[0], ovf_v[0], zero_v[0], r4}, {3'b100, 4'b0010});
      do_op(0, 1'b1, 32'd3, 32'd5, 1, 1'b0);
      chk("sub_3_5", {cout_v[0], ovf_v[0], zero_v[0], r4}, {3'b000, 4'b1110});
      do_op(0, 1'b1, 32'd6, 32'd6, 1, 1'b0);
      chk("sub_6_6", {cout_v[0], ovf_v[0], zero_v[0], r4}, {3'b101, 4'b0000});
      do_op(0, 1'b0, 32'd7, 32'd1, 1, 1'b0);
`ifdef SERIAL_ADDSUB_SAT_EN
      chk("add_7_1", {cout_v[0], ovf_v[0], zero_v[0], r4}, {3'b010, 4'b0111});
`else
      chk("add_7_1", {cout_v[0], ovf_v[0], zero_v[0], r4}, {3'b010, 4'b1000});
`endif
      do_op(0, 1'b1, 32'h8, 32'd1, 1, 1'b0);
`ifdef SERIAL_ADDSUB_SAT_EN
      chk("sub_m8_1", {cout_v[0], ovf_v[0], zero_v[0], r4}, {3'b110, 4'b1000});
`else
      chk("sub_m8_1", {cout_v[0], ovf_v[0], zero_v[0], r4}, {3'b110, 4'b0111});
`endif

      // WIDTH=8: start held into RUN, then a start in the DONE cycle.
      do_op(1, 1'b0, 32'h7F, 32'h01, 4, 1'b0);
`ifdef SERIAL_ADDSUB_SAT_EN
      chk("add_7F_1", {ovf_v[1], r8}, {1'b1, 8'h7F});
`else
      chk("add_7F_1", {ovf_v[1], r8}, {1'b1, 8'h80});
`endif
      do_op(1, 1'b1, 32'h10, 32'h01, 1, 1'b1);
      chk("sub_10_1_b2b", {cout_v[1], ovf_v[1], zero_v[1], r8}, {3'b100, 8'h0F});

      // WIDTH=8: reset in the 3rd RUN cycle aborts the operation.
      @(negedge clk);
      op_v[1] = 1'b0; av[1] = 32'h33; bv[1] = 32'h44; start_v[1] = 1'b1;
      @(negedge clk);
      start_v[1] = 1'b0;
      repeat (2) @(negedge clk);
      rst_v[1] = 1'b1;
      @(negedge clk);
      rst_v[1] = 1'b0;
      chk("abort_state", {busy_v[1], done_v[1], cout_v[1], ovf_v[1], zero_v[1], r8}, 13'd0);
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done_v[1]) saw_done = 1'b1;
      end
      chk("abort_no_done", 64'(saw_done), 64'd0);
      do_op(1, 1'b0, 32'd2, 32'd3, 1, 1'b0);
      chk("add_2_3", {cout_v[1], ovf_v[1], zero_v[1], r8}, {3'b000, 8'h05});

      // Random phase, checked by the per-cycle model compare.
      for (int t = 0; t < 150; t++) begin
         int  ii;
         ii = int'($urandom_range(0, 1));
         do_op(ii, 1'($urandom), $urandom, ($urandom_range(0, 7) == 0) ? av[ii] : $urandom,
               int'($urandom_range(1, 2)), 1'($urandom));
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_serial_addsub
